// File: rtl/maxpool_window_3x3_pkg.sv
// maxpool_window_3x3_pkg: shared word width, window slot indices and window-count helper.
package maxpool_window_3x3_pkg;
    localparam int DATA_W = 32;
    localparam int WIN_N  = 9;
    localparam int WIN_TL = 0;
    localparam int WIN_TC = 1;
    localparam int WIN_TR = 2;
    localparam int WIN_ML = 3;
    localparam int WIN_MC = 4;
    localparam int WIN_MR = 5;
    localparam int WIN_BL = 6;
    localparam int WIN_BC = 7;
    localparam int WIN_BR = 8;

    function automatic int win_count(int w, int h, int s);
        return ((h - 3) / s + 1) * ((w - 3) / s + 1);
    endfunction
endpackage

// File: rtl/maxpool_window_3x3_if.sv
// maxpool_window_3x3_if: pixel stream in, 3x3 window out, with frame-end marker.
interface maxpool_window_3x3_if #(parameter int DATA_W = maxpool_window_3x3_pkg::DATA_W);
    logic              Valid_In;
    logic [DATA_W-1:0] Data_In;
    logic [DATA_W-1:0] Data_Out0, Data_Out1, Data_Out2;
    logic [DATA_W-1:0] Data_Out3, Data_Out4, Data_Out5;
    logic [DATA_W-1:0] Data_Out6, Data_Out7, Data_Out8;
    logic              Valid_Out;
    logic              Frame_Done;

    modport master (
        output Valid_In, Data_In,
        input  Data_Out0, Data_Out1, Data_Out2, Data_Out3, Data_Out4,
        input  Data_Out5, Data_Out6, Data_Out7, Data_Out8, Valid_Out, Frame_Done
    );
    modport slave (
        input  Valid_In, Data_In,
        output Data_Out0, Data_Out1, Data_Out2, Data_Out3, Data_Out4,
        output Data_Out5, Data_Out6, Data_Out7, Data_Out8, Valid_Out, Frame_Done
    );
endinterface

// File: rtl/maxpool_window_3x3_line_buffer.sv
// maxpool_window_3x3_line_buffer: single-port row store, asynchronous read of the old word, write on clk.
module maxpool_window_3x3_line_buffer #(
    parameter int DEPTH  = 28,
    parameter int DATA_W = 32
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [DATA_W-1:0]        wdata,
    output logic [DATA_W-1:0]        rdata
);
    logic [DATA_W-1:0] mem_q [DEPTH];

    assign rdata = mem_q[addr];

    always_ff @(posedge clk) begin
        if (we) mem_q[addr] <= wdata;
    end
endmodule

// File: rtl/maxpool_window_3x3.sv
// maxpool_window_3x3: raster pixel stream to strided 3x3 windows via two line buffers.
// Windows are only released once three full current-frame rows and columns are in the register window.
module maxpool_window_3x3 #(
    parameter int DATA_W = maxpool_window_3x3_pkg::DATA_W,
    parameter int IMG_W  = 28,
    parameter int IMG_H  = 28,
    parameter int STRIDE = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    maxpool_window_3x3_if.slave  bus
);
    import maxpool_window_3x3_pkg::*;

    localparam int CW     = $clog2(IMG_W);
    localparam int RW     = $clog2(IMG_H);
    localparam int LAST_C = 2 + ((IMG_W - 3) / STRIDE) * STRIDE;
    localparam int LAST_R = 2 + ((IMG_H - 3) / STRIDE) * STRIDE;

    logic [CW-1:0]     col_q, col_d;
    logic [RW-1:0]     row_q, row_d;
    logic [1:0]        col_ph_q, col_ph_d, row_ph_q, row_ph_d;
    logic [DATA_W-1:0] win_q [WIN_N];
    logic [DATA_W-1:0] win_d [WIN_N];
    logic [DATA_W-1:0] out_q [WIN_N];
    logic [DATA_W-1:0] out_d [WIN_N];
    logic [DATA_W-1:0] new_col [3];
    logic              valid_q, valid_d, done_q, done_d;
    logic              accept, emit, col_end, row_end;
    logic [DATA_W-1:0] lb0_rd, lb1_rd;

    function automatic logic [1:0] ph_inc(logic [1:0] p);
        return (p == 2'(STRIDE - 1)) ? 2'd0 : p + 2'd1;
    endfunction

    // Reset drops a coincident pixel, so it must not reach the line buffers either.
    assign accept = bus.Valid_In && !rst;

    maxpool_window_3x3_line_buffer #(.DEPTH(IMG_W), .DATA_W(DATA_W)) u_lb0 (
        .clk(clk), .we(accept), .addr(col_q), .wdata(bus.Data_In), .rdata(lb0_rd)
    );
    maxpool_window_3x3_line_buffer #(.DEPTH(IMG_W), .DATA_W(DATA_W)) u_lb1 (
        .clk(clk), .we(accept), .addr(col_q), .wdata(lb0_rd), .rdata(lb1_rd)
    );

    always_comb begin
        new_col[0] = lb1_rd;
        new_col[1] = lb0_rd;
        new_col[2] = bus.Data_In;
        col_end    = col_q == CW'(IMG_W - 1);
        row_end    = row_q == RW'(IMG_H - 1);
        emit       = accept && row_q >= RW'(2) && col_q >= CW'(2) && col_ph_q == 2'd0 && row_ph_q == 2'd0;
        col_d      = accept ? (col_end ? '0 : col_q + 1'b1) : col_q;
        row_d      = (accept && col_end) ? (row_end ? '0 : row_q + 1'b1) : row_q;
        col_ph_d   = accept ? ((col_d == CW'(2)) ? 2'd0 : ph_inc(col_ph_q)) : col_ph_q;
        row_ph_d   = (accept && col_end) ? ((row_d == RW'(2)) ? 2'd0 : ph_inc(row_ph_q)) : row_ph_q;
        for (int i = 0; i < 3; i++) begin
            win_d[3*i]   = accept ? win_q[3*i+1] : win_q[3*i];
            win_d[3*i+1] = accept ? win_q[3*i+2] : win_q[3*i+1];
            win_d[3*i+2] = accept ? new_col[i]   : win_q[3*i+2];
        end
        for (int i = 0; i < WIN_N; i++) out_d[i] = emit ? win_d[i] : out_q[i];
        valid_d    = emit;
        done_d     = emit && row_q == RW'(LAST_R) && col_q == CW'(LAST_C);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col_q    <= '0;
            row_q    <= '0;
            col_ph_q <= '0;
            row_ph_q <= '0;
            win_q    <= '{default: '0};
            out_q    <= '{default: '0};
            valid_q  <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            col_q    <= col_d;
            row_q    <= row_d;
            col_ph_q <= col_ph_d;
            row_ph_q <= row_ph_d;
            win_q    <= win_d;
            out_q    <= out_d;
            valid_q  <= valid_d;
            done_q   <= done_d;
        end
    end

    assign bus.Data_Out0  = out_q[WIN_TL];
    assign bus.Data_Out1  = out_q[WIN_TC];
    assign bus.Data_Out2  = out_q[WIN_TR];
    assign bus.Data_Out3  = out_q[WIN_ML];
    assign bus.Data_Out4  = out_q[WIN_MC];
    assign bus.Data_Out5  = out_q[WIN_MR];
    assign bus.Data_Out6  = out_q[WIN_BL];
    assign bus.Data_Out7  = out_q[WIN_BC];
    assign bus.Data_Out8  = out_q[WIN_BR];
    assign bus.Valid_Out  = valid_q;
    assign bus.Frame_Done = done_q;
endmodule

// File: doc/maxpool_window_3x3.md
Name: maxpool_window_3x3

Overview:
Upstream feeder for the 3x3 max-pool comparator (Find_Max_3x3). It accepts a raster-order stream of float32 feature-map pixels, one per valid beat, and buffers the previous two rows in on-chip line buffers. It emits a 3x3 window of nine words, strided per STRIDE, whose ports map one-to-one onto the comparator's Data_In0..8 / Valid_In. Pixel words are opaque: no arithmetic is performed on them.

Parameters:
DATA_W, 32, pixel word width (IEEE-754 single).
IMG_W, 28, feature-map width in pixels (>=3).
IMG_H, 28, feature-map height in pixels (>=3).
STRIDE, 2, window step in both directions (1..3).

Ports:
clk  in  1  system clock; all logic on rising edge.
rst  in  1  synchronous reset, active-high.
Valid_In  in  1  Data_In holds a pixel this cycle.
Data_In  in  DATA_W  pixel, raster order (row-major, left to right).
Data_Out0..Data_Out8  out  DATA_W each  window, row-major: 0 = top-left, 2 = top-right, 4 = centre, 8 = bottom-right.
Valid_Out  out  1  window valid; one-cycle pulse per window.
Frame_Done  out  1  pulses together with the last window of a frame.

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset: Valid_Out=0, Frame_Done=0, Data_Out0..8=0. Column/row counters and stride-phase counters are cleared to 0. Line-buffer RAM is not cleared.
- Backpressure: none. The downstream block accepts every Valid_Out beat.
- Idle beats: a cycle with Valid_In=0 changes no state, and Valid_Out=0 on the following cycle.
- Storage:
  - Two line buffers of IMG_W words each. LB0 holds row r-1 and LB1 holds row r-2, both addressed by col.
  - On each accepted pixel, LB1[col]<=LB0[col] and LB0[col]<=Data_In.
- Window shift:
  - A 3x3 register window shifts left one column per accepted pixel.
  - The new right column is {LB1[col], LB0[col], Data_In} (top, middle, bottom).
- Counters:
  - col runs 0..IMG_W-1 and row runs 0..IMG_H-1, advancing per accepted pixel.
  - col wraps to 0 and increments row. At (IMG_H-1, IMG_W-1) both wrap to 0, which starts the next frame.
  - col_ph and row_ph are stride-phase counters. Each clears at col/row = 2 and increments modulo STRIDE. No division is used.
- Window emission:
  - A pixel accepted at (row, col) produces a window when row>=2, col>=2, col_ph==0 and row_ph==0.
  - Valid_Out is registered and asserts exactly 1 cycle after that accepting beat. Data_Out0..8 hold the window during that cycle and are held otherwise.
- Count: windows per frame = ((IMG_H-3)/STRIDE+1) * ((IMG_W-3)/STRIDE+1) (integer division). The default configuration gives 169.
- Row-boundary stale data: at col 0 and 1 the window holds pixels from the previous row's tail. The col>=2 gate suppresses these windows.
- Frame-boundary stale data: rows 0 and 1 of a new frame read the previous frame's rows from the line buffers. The row>=2 gate suppresses these, so no window ever mixes frames.
- Frame_Done: asserts with Valid_Out for the last valid window position of the frame.
- Reset mid-frame: all partial progress is discarded, and the next accepted pixel is (0,0).
- Reset and Valid_In in the same cycle: reset wins and the pixel is dropped.

Decomposition:
- Shared package (pool_pkg):
  - DATA_W.
  - Window index constants WIN_TL..WIN_BR (0..8).
  - Function win_count(W, H, S) for benches.
- One natural sub-module: line_buffer (single-port IMG_W x DATA_W, read-before-write, with write enable). Instantiate it twice.

Test Plan:
- Basic window (IMG_W=IMG_H=5, STRIDE=2): stream pixel k=32'h0000_00kk for k=0..24 continuously.
  - Expect 4 windows.
  - Window 1: Out0..8 = 0,1,2,5,6,7,10,11,12, with Valid_Out 1 cycle after k=12.
  - Window 2: Out0=2, Out8=14.
  - Window 3: Out0=10, Out8=22.
  - Window 4: Out0=12, Out8=24, with Frame_Done=1 on this window only.
- Gapped input: same frame with Valid_In toggling every other cycle.
  - Expect the identical 4 windows.
  - Each Valid_Out exactly 1 cycle after its triggering beat, and never on idle cycles.
- Back-to-back frames: stream k=0..49 continuously (two 5x5 frames).
  - Expect exactly 8 windows.
  - Second frame window 1: Out0=25, Out8=37.
  - No window contains values from both frames.
- Reset mid-frame: send k=0..6, assert rst for 1 cycle with Valid_In=1, then send a full frame k=100..124.
  - Expect exactly 4 windows.
  - First window: Out0=100, Out8=112.
  - All outputs are 0 the cycle after reset.
- Stride 1 (IMG_W=4, IMG_H=4, STRIDE=1): stream k=0..15.
  - Expect 4 windows with Out4 = 5, 6, 9, 10 in order.
  - Frame_Done on the 4th window.
- Default configuration (28x28, STRIDE=2) with random float32 data, windows fed into Find_Max_3x3:
  - 169 windows and one Frame_Done.
  - Every window matches a software reference model.
